decode_skid_stage: RTL
======================

DECODE_SKID_STAGE -- requirements
Module: decode_skid_stage

Interface
REQ-001 SHALL have parameter M_EXT, default 1, meaning RV32M multiply/divide decode enabled (0 = M opcodes illegal).
REQ-002 SHALL have parameter PC_W, default 32, meaning width of the PC carried alongside each instruction.
REQ-003 SHALL have parameter ALU_W, default 5, meaning ALU control code width (wide enough for base and M codes).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: CLK  in  1  clock, all state on rising edge.
REQ-005 SHALL have RST_N  in  1  asynchronous active-low reset.
REQ-006 SHALL have FLUSH  in  1  discard all held and incoming instructions.
REQ-007 SHALL have IN_VALID  in  1, IN_INS  in  32, IN_PC  in  PC_W; IN_READY  out  1, registered upstream handshake.
REQ-008 SHALL have OUT_VALID  out  1, OUT_READY  in  1, OUT_PC  out  PC_W: downstream handshake.
REQ-009 SHALL have OUT_ALU_CNT  out  ALU_W, OUT_COMP_CONT  out  3, OUT_D_CACHE_CONTROL  out  2 {store,load}, OUT_TYPE  out  2, OUT_A_BUS_SEL  out  1, OUT_B_BUS_SEL  out  1.
REQ-010 SHALL have OUT_JUMP, OUT_JUMPR, OUT_CBRANCH, OUT_MULDIV, OUT_ILLEGAL  out  1 each: decoded flags.

Function
REQ-011 Transfer SHALL occur on a rising edge when VALID and READY are both 1 on the same port.
REQ-012 Decode SHALL be registered: instruction accepted at edge k appears on OUT_* in the cycle after edge k (latency 1).
REQ-013 Storage SHALL be a main register plus one skid register; state EMPTY, ONE, FULL.
REQ-014 EMPTY: accept -> ONE. ONE: accept with no drain -> FULL; drain with no accept -> EMPTY; both -> ONE, main reloaded.
REQ-015 FULL: drain -> ONE with skid moved to main; no accept possible.
REQ-016 IN_READY SHALL be 1 exactly when state is not FULL; it is a flop output with no combinational path from OUT_READY.
REQ-017 OUT_VALID SHALL be 1 exactly in states ONE and FULL; OUT_* SHALL be held stable while OUT_VALID=1 and OUT_READY=0.
REQ-018 Order SHALL be preserved: skid entry never overtakes main.
REQ-019 IN_INS==0 on accept SHALL be consumed as a bubble: no state change, not forwarded, not flagged illegal.
REQ-020 Opcode decode SHALL cover lui, auipc, jal, jalr, branch, load, store, op-imm, op, system; unknown nonzero opcode -> OUT_ILLEGAL=1, OUT_TYPE=idle, ALU code idle.
REQ-021 op-imm/op SHALL use funct3 plus bit 30 (sub/sra); bit 30 set with any other funct3, or funct7 not in {0x00,0x20,0x01} -> illegal.
REQ-022 op with funct7=0x01: M_EXT=1 -> OUT_MULDIV=1 and ALU code from funct3 (mul..remu); M_EXT=0 -> illegal.
REQ-023 OUT_COMP_CONT SHALL equal IN_INS[14:12] for every instruction; OUT_D_CACHE_CONTROL, OUT_JUMP, OUT_JUMPR, OUT_CBRANCH SHALL be pure opcode compares.
REQ-024 FLUSH=1 SHALL force state EMPTY at the next edge, drop any same-cycle input and output transfer, and take priority over all other events.
REQ-025 Illegal instructions SHALL still flow through the handshake like legal ones.

Reset
REQ-026 RST_N=0 SHALL immediately force state EMPTY, OUT_VALID=0, IN_READY=0.
REQ-027 During reset all OUT_* payload SHALL be 0; IN_READY SHALL rise in the first cycle after reset release.
REQ-028 Reset mid-transfer SHALL lose held entries with no partial output.

Structure
REQ-029 Opcode, funct3, ALU codes, TYPE codes and bus-select codes SHALL live in the shared pipeline parameter package, widened to ALU_W.
REQ-030 One combinational sub-module decode_comb (instruction -> control bundle) SHALL be instantiated once at the input, before the registers.

Verification
REQ-031 Reset, then 0x00208033 (add) with OUT_READY=1 -> next cycle OUT_VALID=1, ALU add, A=rs2, B=rs1, TYPE alu, ILLEGAL=0.
REQ-032 0x40208033 then 0x4020D033 -> ALU sub then sra; 0x40209033 -> ILLEGAL=1.
REQ-033 0x02208033 (mul): M_EXT=1 -> MULDIV=1, ALU mul; M_EXT=0 -> ILLEGAL=1, MULDIV=0.
REQ-034 OUT_READY=0, push 3 instrs back-to-back -> IN_READY=0 after 2nd accepted; release -> outputs appear in order, no loss/duplication.
REQ-035 State FULL, assert FLUSH one cycle with IN_VALID=1 -> OUT_VALID=0 next cycle, IN_READY=1, nothing from before or during flush emerges.
REQ-036 IN_INS=0x00000000 with IN_VALID=1 -> accepted, OUT_VALID stays 0, ILLEGAL never asserted.

Source files
------------

// File: rtl/decode_skid_stage_pkg.sv
// Shared pipeline parameters for the decode skid stage: opcodes, funct fields,
// ALU/TYPE/bus-select codes and the decoded control bundle.
package decode_skid_stage_pkg;

    localparam int ALU_CODE_W = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    localparam logic [ALU_CODE_W-1:0] ALU_IDLE = 5'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 5'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 5'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 5'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 5'd4;
    localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 5'd5;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 5'd6;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 5'd7;
    localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 5'd8;
    localparam logic [ALU_CODE_W-1:0] ALU_OR   = 5'd9;
    localparam logic [ALU_CODE_W-1:0] ALU_AND  = 5'd10;
    localparam logic [ALU_CODE_W-1:0] ALU_PASS = 5'd11;
    // mul, mulh, mulhsu, mulhu, div, divu, rem, remu follow as ALU_MUL + funct3
    localparam logic [ALU_CODE_W-1:0] ALU_MUL  = 5'd12;

    localparam logic [1:0] TYPE_IDLE = 2'd0;
    localparam logic [1:0] TYPE_ALU  = 2'd1;
    localparam logic [1:0] TYPE_MEM  = 2'd2;
    localparam logic [1:0] TYPE_CTRL = 2'd3;

    localparam logic A_SEL_RS2 = 1'b0;
    localparam logic A_SEL_IMM = 1'b1;
    localparam logic B_SEL_RS1 = 1'b0;
    localparam logic B_SEL_PC  = 1'b1;

    typedef struct packed {
        logic [ALU_CODE_W-1:0] alu_cnt;
        logic [2:0]            comp_cont;
        logic [1:0]            d_cache_control;
        logic [1:0]            typ;
        logic                  a_bus_sel;
        logic                  b_bus_sel;
        logic                  jump;
        logic                  jumpr;
        logic                  cbranch;
        logic                  muldiv;
        logic                  illegal;
    } ctrl_t;

    function automatic logic [ALU_CODE_W-1:0] base_alu(input logic [2:0] f3, input logic alt);
        logic [ALU_CODE_W-1:0] code;
        case (f3)
            F3_ADD:  code = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  code = ALU_SLL;
            F3_SLT:  code = ALU_SLT;
            F3_SLTU: code = ALU_SLTU;
            F3_XOR:  code = ALU_XOR;
            F3_SR:   code = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/decode_skid_stage_decode_comb.sv
// Purely combinational RV32I(+M) decoder: 32-bit instruction to control bundle.
module decode_comb
    import decode_skid_stage_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic [31:0] i_ins,
    output ctrl_t       o_ctrl
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_illegal;
    ctrl_t      w_ctrl;
    logic       w_unused_fields;

    assign w_opcode        = i_ins[6:0];
    assign w_f3            = i_ins[14:12];
    assign w_f7            = i_ins[31:25];
    assign w_unused_fields = ^{i_ins[24:15], i_ins[11:7]};

    always_comb begin
        w_illegal                = 1'b0;
        w_ctrl                   = '0;
        w_ctrl.comp_cont         = w_f3;
        w_ctrl.d_cache_control   = {w_opcode == OP_STORE, w_opcode == OP_LOAD};
        w_ctrl.jump              = (w_opcode == OP_JAL);
        w_ctrl.jumpr             = (w_opcode == OP_JALR);
        w_ctrl.cbranch           = (w_opcode == OP_BRANCH);
        case (w_opcode)
            OP_LUI: begin
                w_ctrl.alu_cnt   = ALU_PASS;
                w_ctrl.typ       = TYPE_ALU;
                w_ctrl.a_bus_sel = A_SEL_IMM;
            end
            OP_AUIPC: begin
                w_ctrl.alu_cnt   = ALU_ADD;
                w_ctrl.typ       = TYPE_ALU;
                w_ctrl.a_bus_sel = A_SEL_IMM;
                w_ctrl.b_bus_sel = B_SEL_PC;
            end
            OP_JAL, OP_BRANCH: begin
                w_ctrl.alu_cnt   = ALU_ADD;
                w_ctrl.typ       = TYPE_CTRL;
                w_ctrl.a_bus_sel = A_SEL_IMM;
                w_ctrl.b_bus_sel = B_SEL_PC;
            end
            OP_JALR: begin
                w_ctrl.alu_cnt   = ALU_ADD;
                w_ctrl.typ       = TYPE_CTRL;
                w_ctrl.a_bus_sel = A_SEL_IMM;
                w_ctrl.b_bus_sel = B_SEL_RS1;
            end
            OP_LOAD, OP_STORE: begin
                w_ctrl.alu_cnt   = ALU_ADD;
                w_ctrl.typ       = TYPE_MEM;
                w_ctrl.a_bus_sel = A_SEL_IMM;
                w_ctrl.b_bus_sel = B_SEL_RS1;
            end
            OP_IMM: begin
                // Bits 31:25 are immediate except for shifts, where they act as funct7.
                w_ctrl.typ       = TYPE_ALU;
                w_ctrl.a_bus_sel = A_SEL_IMM;
                if (w_f3 == F3_SLL && w_f7 != F7_BASE)
                    w_illegal = 1'b1;
                else if (w_f3 == F3_SR && w_f7 != F7_BASE && w_f7 != F7_ALT)
                    w_illegal = 1'b1;
                else
                    w_ctrl.alu_cnt = base_alu(w_f3, (w_f3 == F3_SR) && i_ins[30]);
            end
            OP_OP: begin
                w_ctrl.typ       = TYPE_ALU;
                w_ctrl.a_bus_sel = A_SEL_RS2;
                w_ctrl.b_bus_sel = B_SEL_RS1;
                case (w_f7)
                    F7_BASE: w_ctrl.alu_cnt = base_alu(w_f3, 1'b0);
                    F7_ALT: begin
                        if (w_f3 == F3_ADD || w_f3 == F3_SR)
                            w_ctrl.alu_cnt = base_alu(w_f3, 1'b1);
                        else
                            w_illegal = 1'b1;
                    end
                    F7_MULDIV: begin
                        if (M_EXT != 0) begin
                            w_ctrl.muldiv  = 1'b1;
                            w_ctrl.alu_cnt = ALU_MUL + {2'b00, w_f3};
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_SYSTEM: begin
                w_ctrl.typ = TYPE_IDLE;
            end
            default: w_illegal = 1'b1;
        endcase

        o_ctrl = w_ctrl;
        if (w_illegal) begin
            o_ctrl.alu_cnt   = ALU_IDLE;
            o_ctrl.typ       = TYPE_IDLE;
            o_ctrl.a_bus_sel = 1'b0;
            o_ctrl.b_bus_sel = 1'b0;
            o_ctrl.muldiv    = 1'b0;
        end
        o_ctrl.illegal = w_illegal;
    end

endmodule

// File: rtl/decode_skid_stage.sv
// Registered decode stage with a main + skid buffer; IN_READY is a flop so the
// upstream handshake has no combinational path from OUT_READY.
module decode_skid_stage
    import decode_skid_stage_pkg::*;
#(
    parameter int M_EXT = 1,
    parameter int PC_W  = 32,
    parameter int ALU_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_in_valid,
    input  logic [31:0]      i_in_ins,
    input  logic [PC_W-1:0]  i_in_pc,
    output logic             o_in_ready,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [PC_W-1:0]  o_out_pc,
    output logic [ALU_W-1:0] o_out_alu_cnt,
    output logic [2:0]       o_out_comp_cont,
    output logic [1:0]       o_out_d_cache_control,
    output logic [1:0]       o_out_type,
    output logic             o_out_a_bus_sel,
    output logic             o_out_b_bus_sel,
    output logic             o_out_jump,
    output logic             o_out_jumpr,
    output logic             o_out_cbranch,
    output logic             o_out_muldiv,
    output logic             o_out_illegal,
    output logic [1:0]       o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]      r_state;
    logic            r_in_ready;
    ctrl_t           r_main_ctrl;
    logic [PC_W-1:0] r_main_pc;
    ctrl_t           r_skid_ctrl;
    logic [PC_W-1:0] r_skid_pc;

    ctrl_t      w_in_ctrl;
    logic [1:0] w_next_state;
    logic       w_push;
    logic       w_drain;
    logic       w_out_valid;
    logic       w_load_main;
    logic       w_load_skid;
    logic       w_skid_to_main;

    decode_comb #(.M_EXT(M_EXT)) u_decode (
        .i_ins  (i_in_ins),
        .o_ctrl (w_in_ctrl)
    );

    assign w_out_valid = (r_state == ST_ONE) || (r_state == ST_FULL);
    // An all-zero word is accepted but never stored, so it leaves no trace downstream.
    assign w_push      = i_in_valid && r_in_ready && (i_in_ins != 32'd0) && !i_flush;
    assign w_drain     = w_out_valid && i_out_ready && !i_flush;

    always_comb begin
        w_next_state   = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (i_flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_next_state = ST_ONE;
                        w_load_main  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_push && !w_drain) begin
                        w_next_state = ST_FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_drain && !w_push) begin
                        w_next_state = ST_EMPTY;
                    end else if (w_push && w_drain) begin
                        w_load_main  = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        w_next_state   = ST_ONE;
                        w_skid_to_main = 1'b1;
                    end
                end
                default: w_next_state = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_main_ctrl <= '0;
            r_main_pc   <= '0;
            r_skid_ctrl <= '0;
            r_skid_pc   <= '0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_FULL);
            if (w_load_main) begin
                r_main_ctrl <= w_in_ctrl;
                r_main_pc   <= i_in_pc;
            end else if (w_skid_to_main) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_pc   <= r_skid_pc;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= w_in_ctrl;
                r_skid_pc   <= i_in_pc;
            end
        end
    end

    assign o_in_ready            = r_in_ready;
    assign o_out_valid           = w_out_valid;
    assign o_out_pc              = r_main_pc;
    assign o_out_alu_cnt         = ALU_W'(r_main_ctrl.alu_cnt);
    assign o_out_comp_cont       = r_main_ctrl.comp_cont;
    assign o_out_d_cache_control = r_main_ctrl.d_cache_control;
    assign o_out_type            = r_main_ctrl.typ;
    assign o_out_a_bus_sel       = r_main_ctrl.a_bus_sel;
    assign o_out_b_bus_sel       = r_main_ctrl.b_bus_sel;
    assign o_out_jump            = r_main_ctrl.jump;
    assign o_out_jumpr           = r_main_ctrl.jumpr;
    assign o_out_cbranch         = r_main_ctrl.cbranch;
    assign o_out_muldiv          = r_main_ctrl.muldiv;
    assign o_out_illegal         = r_main_ctrl.illegal;
    assign o_dbg_state           = r_state;

endmodule
